// File: rtl/cntr_updn_n_pkg.sv
// Shared definitions for the up/down counter family.
// Contents: o_state width and operation encodings reported on o_state.
package cntr_pkg;

   localparam int unsigned CNTR_STATE_W = 3;

   // Operation performed on the last clock edge
   localparam logic [CNTR_STATE_W-1:0] CNTR_IDLE = 3'd0;
   localparam logic [CNTR_STATE_W-1:0] CNTR_LOAD = 3'd1;
   localparam logic [CNTR_STATE_W-1:0] CNTR_INC  = 3'd2;
   localparam logic [CNTR_STATE_W-1:0] CNTR_DEC  = 3'd3;
   localparam logic [CNTR_STATE_W-1:0] CNTR_CLR  = 3'd4;
   localparam logic [CNTR_STATE_W-1:0] CNTR_SAT  = 3'd5;

endpackage : cntr_pkg

// File: rtl/cntr_updn_n_if.sv
// Control/status bundle of cntr_updn_n.
// master: drives en, clr, load, inc, dec, d_in; observes d_out, o_state, o_tc, o_wrap, o_ovf.
// slave : the counter itself (opposite directions).
interface cntr_updn_n_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic                                en;
   logic                                clr;
   logic                                load;
   logic                                inc;
   logic                                dec;
   logic [WIDTH-1:0]                    d_in;
   logic [WIDTH-1:0]                    d_out;
   logic [cntr_pkg::CNTR_STATE_W-1:0]   o_state;
   logic                                o_tc;
   logic                                o_wrap;
   logic                                o_ovf;

   modport master (
      output en, clr, load, inc, dec, d_in,
      input  d_out, o_state, o_tc, o_wrap, o_ovf
   );

   modport slave (
      input  en, clr, load, inc, dec, d_in,
      output d_out, o_state, o_tc, o_wrap, o_ovf
   );

endinterface : cntr_updn_n_if

// File: rtl/cntr_updn_n_next.sv
// Combinational next-count unit: applies one +/-STEP move to cnt_i within 0..MAX,
// wrapping modulo MAX+1 (SAT=0) or clamping at the limit (SAT=1).
// Ports: cnt_i current count, up_i 1=increment/0=decrement,
//        nxt_o resulting count, wrap_o 1 when the move wrapped or clamped.
module cntr_updn_n_next #(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  MAX   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0]  STEP  = WIDTH'(1),
   parameter bit                SAT   = 1'b0
) (
   input  logic [WIDTH-1:0] cnt_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] nxt_o,
   output logic             wrap_o
);

   localparam int unsigned XW = WIDTH + 1;

   logic [XW-1:0] cnt_x;
   logic [XW-1:0] step_x;
   logic [XW-1:0] max_x;
   logic [XW-1:0] sum_x;
   logic [XW-1:0] up_wrap_x;
   logic [XW-1:0] dn_wrap_x;

   // One extra bit so cnt+STEP and cnt+MAX+1 never overflow
   always_comb begin
      cnt_x     = XW'(cnt_i);
      step_x    = XW'(STEP);
      max_x     = XW'(MAX);
      sum_x     = cnt_x + step_x;
      up_wrap_x = sum_x - max_x - XW'(1);
      dn_wrap_x = cnt_x + max_x + XW'(1) - step_x;
      nxt_o     = cnt_i;
      wrap_o    = 1'b0;
      if (up_i) begin
         if (sum_x <= max_x) begin
            nxt_o = sum_x[WIDTH-1:0];
         end else begin
            wrap_o = 1'b1;
            nxt_o  = SAT ? MAX : up_wrap_x[WIDTH-1:0];
         end
      end else begin
         if (cnt_i >= STEP) begin
            nxt_o = cnt_i - STEP;
         end else begin
            wrap_o = 1'b1;
            nxt_o  = SAT ? '0 : dn_wrap_x[WIDTH-1:0];
         end
      end
   end

endmodule : cntr_updn_n_next

// File: rtl/cntr_updn_n.sv
// Parametrised up/down counter with load, synchronous clear, enable and
// terminal-count / wrap / overflow flags.
// Ports: clk, reset_n (async, active low), bus (cntr_updn_n_if.slave):
//        en, clr, load, inc, dec, d_in in; d_out, o_state, o_tc, o_wrap, o_ovf out.
// Build option: define CNTR_UPDN_N_OVF_STICKY_EN for a sticky o_ovf flag;
//        otherwise o_ovf is tied low.
module cntr_updn_n
   import cntr_pkg::*;
#(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  MAX   = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0]  STEP  = WIDTH'(1),
   parameter bit                SAT   = 1'b0
) (
   input  logic          clk,
   input  logic          reset_n,
   cntr_updn_n_if.slave  bus
);

   logic [WIDTH-1:0]        cnt_q,   cnt_d;
   logic [CNTR_STATE_W-1:0] state_q, state_d;
   logic                    up_q,    up_d;
   logic                    tc_q,    tc_d;
   logic                    wrap_q,  wrap_d;
   logic [WIDTH-1:0]        step_val;
   logic                    step_wrap;

   // Single next-value unit; direction comes from inc (inc&dec never uses it)
   cntr_updn_n_next #(
      .WIDTH (WIDTH),
      .MAX   (MAX),
      .STEP  (STEP),
      .SAT   (SAT)
   ) u_next (
      .cnt_i  (cnt_q),
      .up_i   (bus.inc),
      .nxt_o  (step_val),
      .wrap_o (step_wrap)
   );

   // Priority: clr > load > inc&dec (hold) > inc > dec > hold
   always_comb begin
      cnt_d   = cnt_q;
      state_d = CNTR_IDLE;
      up_d    = up_q;
      wrap_d  = 1'b0;
      if (bus.clr) begin
         cnt_d   = '0;
         state_d = CNTR_CLR;
      end else if (bus.load) begin
         cnt_d   = (bus.d_in > MAX) ? MAX : bus.d_in;
         state_d = CNTR_LOAD;
      end else if (bus.en && (bus.inc ^ bus.dec)) begin
         cnt_d  = step_val;
         wrap_d = step_wrap;
         up_d   = bus.inc;
         if (SAT && step_wrap) begin
            state_d = CNTR_SAT;
         end else begin
            state_d = bus.inc ? CNTR_INC : CNTR_DEC;
         end
      end
      // Terminal count registered from next count and next direction
      tc_d = up_d ? (cnt_d == MAX) : (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         state_q <= CNTR_IDLE;
         up_q    <= 1'b1;
         tc_q    <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         up_q    <= up_d;
         tc_q    <= tc_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef CNTR_UPDN_N_OVF_STICKY_EN
   logic ovf_q, ovf_d;

   // Sticky overflow: clr/load win over a same-edge wrap
   always_comb begin
      ovf_d = ovf_q | wrap_d;
      if (bus.clr || bus.load) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.o_ovf = ovf_q;
`else
   assign bus.o_ovf = 1'b0;
`endif

   assign bus.d_out   = cnt_q;
   assign bus.o_state = state_q;
   assign bus.o_tc    = tc_q;
   assign bus.o_wrap  = wrap_q;

endmodule : cntr_updn_n

// File: tb/tb_cntr_updn_n.sv
// Scoreboard bench for cntr_updn_n: three instances (default 8-bit wrap,
// MAX=9/STEP=3 wrap, MAX=9/STEP=1 saturate) share one stimulus stream.
module tb_cntr_updn_n;

   typedef struct packed {
      logic [7:0] cnt;
      logic [2:0] st;
      logic       tc;
      logic       wrap;
      logic       ovf;
   } obs_t;

   localparam int NDUT = 3;
   localparam bit T = 1'b1;
   localparam bit F = 1'b0;

   int mx  [NDUT] = '{255, 9, 9};
   int stp [NDUT] = '{1, 3, 1};
   bit sat [NDUT] = '{1'b0, 1'b0, 1'b1};

   logic clk;
   logic reset_n;

   cntr_updn_n_if #(.WIDTH(8)) bus_a ();
   cntr_updn_n_if #(.WIDTH(8)) bus_b ();
   cntr_updn_n_if #(.WIDTH(8)) bus_c ();

   cntr_updn_n #(.WIDTH(8)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );
   cntr_updn_n #(.WIDTH(8), .MAX(8'd9), .STEP(8'd3), .SAT(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );
   cntr_updn_n #(.WIDTH(8), .MAX(8'd9), .STEP(8'd1), .SAT(1'b1)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(bus_c)
   );

   obs_t act [NDUT];
   always_comb begin
      act[0] = {bus_a.d_out, bus_a.o_state, bus_a.o_tc, bus_a.o_wrap, bus_a.o_ovf};
      act[1] = {bus_b.d_out, bus_b.o_state, bus_b.o_tc, bus_b.o_wrap, bus_b.o_ovf};
      act[2] = {bus_c.d_out, bus_c.o_state, bus_c.o_tc, bus_c.o_wrap, bus_c.o_ovf};
   end

   obs_t exp_q [NDUT][$];
   int   m_cnt [NDUT];
   bit   m_up  [NDUT];
   bit   m_ovf [NDUT];
   int   vectors;
   int   miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_cnt[k] = 0;
         m_up[k]  = 1'b1;
         m_ovf[k] = 1'b0;
      end
   endfunction

   task automatic check(input int k, input obs_t want);
      vectors++;
      if (act[k] !== want) begin
         miscompares++;
         $display("FAIL dut%0d t=%0t: got cnt=%0d st=%0d tc=%0b wrap=%0b ovf=%0b, want cnt=%0d st=%0d tc=%0b wrap=%0b ovf=%0b",
                  k, $time, act[k].cnt, act[k].st, act[k].tc, act[k].wrap, act[k].ovf,
                  want.cnt, want.st, want.tc, want.wrap, want.ovf);
      end
   endtask

   task automatic set_inputs(input bit en_v, input bit clr_v, input bit load_v,
                             input bit inc_v, input bit dec_v, input logic [7:0] din);
      bus_a.en = en_v; bus_a.clr = clr_v; bus_a.load = load_v;
      bus_a.inc = inc_v; bus_a.dec = dec_v; bus_a.d_in = din;
      bus_b.en = en_v; bus_b.clr = clr_v; bus_b.load = load_v;
      bus_b.inc = inc_v; bus_b.dec = dec_v; bus_b.d_in = din;
      bus_c.en = en_v; bus_c.clr = clr_v; bus_c.load = load_v;
      bus_c.inc = inc_v; bus_c.dec = dec_v; bus_c.d_in = din;
   endtask

   // Apply one cycle of stimulus and queue each instance's expected result
   task automatic drive(input bit en_v, input bit clr_v, input bit load_v,
                        input bit inc_v, input bit dec_v, input logic [7:0] din);
      obs_t e;
      int   v;
      @(negedge clk);
      set_inputs(en_v, clr_v, load_v, inc_v, dec_v, din);
      for (int k = 0; k < NDUT; k++) begin
         e = '0;
         if (clr_v) begin
            m_cnt[k] = 0;
            e.st     = 3'd4;
         end else if (load_v) begin
            m_cnt[k] = (int'(din) > mx[k]) ? mx[k] : int'(din);
            e.st     = 3'd1;
         end else if (en_v && inc_v && dec_v) begin
            e.st = 3'd0;
         end else if (en_v && inc_v) begin
            m_up[k] = 1'b1;
            v       = m_cnt[k] + stp[k];
            e.st    = 3'd2;
            if (v > mx[k]) begin
               e.wrap = 1'b1;
               if (sat[k]) begin
                  v    = mx[k];
                  e.st = 3'd5;
               end else begin
                  v = v - (mx[k] + 1);
               end
            end
            m_cnt[k] = v;
         end else if (en_v && dec_v) begin
            m_up[k] = 1'b0;
            v       = m_cnt[k] - stp[k];
            e.st    = 3'd3;
            if (v < 0) begin
               e.wrap = 1'b1;
               if (sat[k]) begin
                  v    = 0;
                  e.st = 3'd5;
               end else begin
                  v = v + mx[k] + 1;
               end
            end
            m_cnt[k] = v;
         end
`ifdef CNTR_UPDN_N_OVF_STICKY_EN
         if (clr_v || load_v) m_ovf[k] = 1'b0;
         else if (e.wrap)     m_ovf[k] = 1'b1;
`else
         m_ovf[k] = 1'b0;
`endif
         e.cnt = 8'(m_cnt[k]);
         e.tc  = m_up[k] ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
         e.ovf = m_ovf[k];
         exp_q[k].push_back(e);
      end
   endtask

   // Monitor: the counter presents a result every edge; pop and compare
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NDUT; k++) begin
            if (exp_q[k].size() > 0) check(k, exp_q[k].pop_front());
         end
      end
   end

   initial begin
      int waited;
      bit pending;
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      set_inputs(F, F, F, F, F, 8'd0);
      model_reset();
      #12;
      for (int k = 0; k < NDUT; k++) check(k, obs_t'(0));
      #10.5 reset_n = 1'b1;

      // Plain counting
      repeat (5) drive(T, F, F, T, F, 8'd0);
      // Wrap across the top of the 8-bit range
      drive(T, F, T, F, F, 8'hFE);
      repeat (3) drive(T, F, F, T, F, 8'd0);
      // Wrap both ways with a large step
      drive(T, F, T, F, F, 8'd8);
      drive(T, F, F, T, F, 8'd0);
      drive(T, F, F, F, T, 8'd0);
      // Clamped load, saturate at top then bottom
      drive(T, F, T, F, F, 8'd12);
      drive(T, F, F, T, F, 8'd0);
      repeat (11) drive(T, F, F, F, T, 8'd0);
      // Simultaneous events and enable gating
      drive(T, T, T, T, F, 8'h55);
      drive(T, F, T, F, F, 8'h05);
      drive(T, F, F, T, T, 8'd0);
      drive(F, F, F, T, F, 8'd0);
      drive(F, F, T, F, F, 8'h07);
      // Randomized traffic
      repeat (400) begin
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) == 0),
               bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), 8'($urandom));
      end
      // Asynchronous reset in the middle of a count at 37
      drive(T, F, T, F, F, 8'd35);
      drive(T, F, F, T, F, 8'd0);
      drive(T, F, F, T, F, 8'd0);
      @(negedge clk);
      set_inputs(F, F, F, F, F, 8'd0);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < NDUT; k++) check(k, obs_t'(0));
      @(negedge clk);
      #2.5 reset_n = 1'b1;
      repeat (2) drive(T, F, F, T, F, 8'd0);

      // Drain the scoreboard with a bounded wait
      waited  = 0;
      pending = 1'b1;
      while (pending && waited < 5) begin
         @(posedge clk);
         #2;
         waited++;
         pending = 1'b0;
         for (int k = 0; k < NDUT; k++) if (exp_q[k].size() > 0) pending = 1'b1;
      end
      if (pending) begin
         miscompares++;
         $display("FAIL drain: results still queued after %0d cycles, want none", waited);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_cntr_updn_n
